rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter.sv | 101 ++++++++++
 tb/tb_rom_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// Two-port round-robin arbiter that shares one registered-read ROM.
// The winner gets one burst of 1..4 consecutive reads, and the read address wraps at the top of the ROM.
module rom_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              p0_req,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [1:0]        p0_len,
  output logic              p0_gnt,
  output logic              p0_valid,
  input  logic              p1_req,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [1:0]        p1_len,
  output logic              p1_gnt,
  output logic              p1_valid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] rom_addra,
  input  logic [DATA_W-1:0] rom_douta,
  output logic              busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_owner;     // 0 = p0, 1 = p1
  logic              r_prio_p1;   // 1 when p1 wins a tie
  logic [1:0]        r_len;
  logic [1:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_gnt;
  logic [1:0]        r_valid;

  logic w_grant0;
  logic w_grant1;
  logic w_last_beat;

  assign w_grant0    = (r_state == IDLE) && p0_req && (!p1_req || !r_prio_p1);
  assign w_grant1    = (r_state == IDLE) && p1_req && (!p0_req ||  r_prio_p1);
  assign w_last_beat = (r_state == BURST) && (r_cnt == r_len);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clka) begin
    if (rsta) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // NOTE: default assignment first so no path through this block can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_grant0 || w_grant1) w_next = BURST;
      BURST:   if (w_last_beat)          w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      r_owner   <= 1'b0;
      r_prio_p1 <= 1'b0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_gnt     <= '0;
      r_valid   <= '0;
    end else begin
      r_gnt <= {w_grant1, w_grant0};
      // Every BURST cycle issues one beat, and the owner's valid follows one cycle later.
      r_valid <= {(r_state == BURST) &&  r_owner,
                  (r_state == BURST) && !r_owner};
      if (w_grant0 || w_grant1) begin
        r_owner   <= w_grant1;
        r_prio_p1 <= w_grant0;
        r_len     <= w_grant1 ? p1_len  : p0_len;
        r_addr    <= w_grant1 ? p1_addr : p0_addr;
        r_cnt     <= '0;
      end else if ((r_state == BURST) && !w_last_beat) begin
        r_addr <= r_addr + ADDR_W'(1);
        r_cnt  <= r_cnt + 2'd1;
      end
    end
  end

  always_comb begin
    busy      = (r_state == BURST);
    p0_gnt    = r_gnt[0];
    p1_gnt    = r_gnt[1];
    p0_valid  = r_valid[0];
    p1_valid  = r_valid[1];
    rom_addra = r_addr;
    rdata     = rom_douta;
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Randomised bench for rom_arbiter. It models a 128-word registered ROM.
// Expected burst timing and round-robin order are computed from transaction-level rules.
module tb_rom_arbiter;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clka = 1'b0;
  logic              rsta;
  logic              p0_req, p1_req;
  logic [ADDR_W-1:0] p0_addr, p1_addr;
  logic [1:0]        p0_len, p1_len;
  logic              p0_gnt, p1_gnt, p0_valid, p1_valid, busy;
  logic [DATA_W-1:0] rdata, rom_douta;
  logic [ADDR_W-1:0] rom_addra;

  logic [DATA_W-1:0] rom [DEPTH];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clka = ~clka;

  always @(posedge clka) rom_douta <= rom[rom_addra];

  rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clka(clka), .rsta(rsta),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_len(p0_len), .p0_gnt(p0_gnt), .p0_valid(p0_valid),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_len(p1_len), .p1_gnt(p1_gnt), .p1_valid(p1_valid),
    .rdata(rdata), .rom_addra(rom_addra), .rom_douta(rom_douta), .busy(busy)
  );

  // Packs {p0_gnt, p1_gnt, p0_valid, p1_valid, busy} into one vector.
  function automatic logic [4:0] ctl();
    return {p0_gnt, p1_gnt, p0_valid, p1_valid, busy};
  endfunction

  task automatic test_reset();
    rsta = 1'b1;
    p0_req = 1'b1; p1_req = 1'b1;
    p0_addr = 7'd33; p1_addr = 7'd66; p0_len = 2'd3; p1_len = 2'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clka);
      if (i == 1) rsta = 1'b0;
      if (i == 0) continue;
      n_cmp++;
      if (ctl() !== 5'b0) begin
        n_err++;
        $display("FAIL reset_ctl[%0d]: got %b, want 00000", i, ctl());
      end
      n_cmp++;
      if (rom_addra !== 7'd0) begin
        n_err++;
        $display("FAIL reset_addr[%0d]: got %0d, want 0", i, rom_addra);
      end
    end
    p0_req = 1'b0; p1_req = 1'b0;
    @(negedge clka);
  endtask

  // Runs one request to completion and checks gnt, beat addresses, valids and data.
  task automatic do_burst(input bit port, input logic [ADDR_W-1:0] a, input logic [1:0] l,
                          input string tag);
    bit got = 1'b0;
    logic [4:0] exp_ctl;
    logic [ADDR_W-1:0] exp_addr, beat_addr;
    if (port) begin p1_req = 1'b1; p1_addr = a; p1_len = l; end
    else      begin p0_req = 1'b1; p0_addr = a; p0_len = l; end
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clka);
      if (p0_gnt || p1_gnt) got = 1'b1;
    end
    p0_req = 1'b0; p1_req = 1'b0;
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL %s_gnt_timeout: got no grant, want a grant within 10 cycles", tag);
      return;
    end
    for (int c = 0; c <= int'(l) + 1; c++) begin
      if (c > 0) @(negedge clka);
      exp_ctl = {c == 0 && !port, c == 0 && port, c >= 1 && !port, c >= 1 && port, c <= int'(l)};
      n_cmp++;
      if (ctl() !== exp_ctl) begin
        n_err++;
        $display("FAIL %s_ctl[c%0d]: got %b, want %b", tag, c, ctl(), exp_ctl);
      end
      exp_addr = ADDR_W'(int'(a) + ((c <= int'(l)) ? c : int'(l)));
      n_cmp++;
      if (rom_addra !== exp_addr) begin
        n_err++;
        $display("FAIL %s_addr[c%0d]: got %0d, want %0d", tag, c, rom_addra, exp_addr);
      end
      if (c >= 1) begin
        beat_addr = ADDR_W'(int'(a) + c - 1);
        n_cmp++;
        if (rdata !== rom[beat_addr]) begin
          n_err++;
          $display("FAIL %s_rdata[beat%0d]: got %h, want %h", tag, c - 1, rdata, rom[beat_addr]);
        end
      end
    end
    @(negedge clka);
    n_cmp++;
    if (ctl() !== 5'b0) begin
      n_err++;
      $display("FAIL %s_quiet: got %b, want 00000", tag, ctl());
    end
  endtask

  // Both ports keep requesting. The winners must alternate, with one burst length plus one idle cycle between grants.
  task automatic test_contention(input logic [1:0] l0, input logic [1:0] l1, input bit first,
                                 output bit next_w, input string tag);
    logic [ADDR_W-1:0] a0, a1;
    int next_gnt = 1;
    bit w = first;
    a0 = ADDR_W'($urandom); a1 = ADDR_W'($urandom);
    p0_req = 1'b1; p0_addr = a0; p0_len = l0;
    p1_req = 1'b1; p1_addr = a1; p1_len = l1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clka);
      n_cmp++;
      if (c == next_gnt) begin
        if ({p0_gnt, p1_gnt} !== {!w, w} || rom_addra !== (w ? a1 : a0)) begin
          n_err++;
          $display("FAIL %s_gnt[c%0d]: got gnt=%b addr=%0d, want gnt=%b addr=%0d",
                   tag, c, {p0_gnt, p1_gnt}, rom_addra, {!w, w}, w ? a1 : a0);
        end
        next_gnt = c + int'(w ? l1 : l0) + 2;
        w = !w;
      end else if ({p0_gnt, p1_gnt} !== 2'b00) begin
        n_err++;
        $display("FAIL %s_gnt[c%0d]: got gnt=%b, want 00", tag, c, {p0_gnt, p1_gnt});
      end
      n_cmp++;
      if (p0_valid && p1_valid) begin
        n_err++;
        $display("FAIL %s_valid_excl[c%0d]: got both valids high, want at most one", tag, c);
      end
    end
    p0_req = 1'b0; p1_req = 1'b0;
    // If a grant fell on cycle 20, the DUT still issues that burst, so the model's next winner is correct either way.
    next_w = w;
    for (int i = 0; i < 8; i++) @(negedge clka);
    n_cmp++;
    if (ctl() !== 5'b0) begin
      n_err++;
      $display("FAIL %s_drain: got %b, want 00000", tag, ctl());
    end
  endtask

  task automatic test_reset_midburst();
    p0_req = 1'b1; p0_addr = 7'd10; p0_len = 2'd3;
    @(negedge clka);
    p0_req = 1'b0;
    n_cmp++;
    if (p0_gnt !== 1'b1 || rom_addra !== 7'd10) begin
      n_err++;
      $display("FAIL midrst_gnt: got gnt=%b addr=%0d, want gnt=1 addr=10", p0_gnt, rom_addra);
    end
    @(negedge clka);
    rsta = 1'b1;
    @(negedge clka);
    rsta = 1'b0;
    n_cmp++;
    if (ctl() !== 5'b0 || rom_addra !== 7'd0) begin
      n_err++;
      $display("FAIL midrst_after: got ctl=%b addr=%0d, want ctl=00000 addr=0", ctl(), rom_addra);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clka);
      n_cmp++;
      if (ctl() !== 5'b0) begin
        n_err++;
        $display("FAIL midrst_quiet[%0d]: got %b, want 00000", i, ctl());
      end
    end
    do_burst(1'b1, ADDR_W'($urandom), 2'($urandom), "midrst_p1");
  endtask

  task automatic test_sweep();
    for (int a = 0; a < 16; a++) do_burst(1'b1, ADDR_W'(a), 2'd0, "sweep");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++)
      do_burst(1'($urandom), ADDR_W'($urandom), 2'($urandom), "rand");
  endtask

  initial begin
    bit nw;
    for (int i = 0; i < DEPTH; i++) rom[i] = $urandom;
    test_reset();
    do_burst(1'b0, 7'd5, 2'd0, "single");
    do_burst(1'b1, 7'd126, 2'd3, "wrap");
    rsta = 1'b1;
    @(negedge clka);
    rsta = 1'b0;
    test_contention(2'd0, 2'd0, 1'b0, nw, "rr_len0");
    test_contention(2'($urandom), 2'($urandom), nw, nw, "rr_rand");
    test_reset_midburst();
    test_sweep();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion, want completion within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
